shift_sequencer: RTL

- Multi-cycle operand-2 shifter for the EXE stage. Accepts one ARM data-processing operand-2 request per transaction, computes Val_2 and the shifter carry-out iteratively, and returns the result over a valid/ready handshake.
- Covers immediate rotate, immediate-amount shifts and register-specified shifts (Rs[7:0]), with full ARM edge semantics (LSR/ASR #32, RRX, amounts >= 32).
- Asserts busy so the hazard unit can stall IF/ID/EXE while a shift is in flight.

---
 rtl/arm_shift_pkg.sv | 55 +++++
 rtl/shift_step_unit.sv | 38 +++
 rtl/shift_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/arm_shift_pkg.sv
// rtl/arm_shift_pkg.sv - shared encodings and request decode for the operand-2 shifter
package arm_shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [5:0] MAX_STEPS = 6'd33;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    // RRX is kept distinct from ROR because its fill bit is the latched carry.
    typedef enum logic [2:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_t;

    typedef struct packed {
        op_t        op;
        logic [5:0] steps;
    } decode_t;

    function automatic decode_t decode_shift(input logic imm, input logic reg_shift,
                                             input logic [11:0] so, input logic [7:0] rs);
        decode_t    d;
        logic [4:0] n;
        logic [4:0] a_m1;
        n       = so[11:7];
        a_m1    = rs[4:0] - 5'd1;
        d.op    = op_t'({1'b0, so[6:5]});
        d.steps = 6'd0;
        if (imm) begin
            d.op    = OP_ROR;
            d.steps = {1'b0, so[11:8], 1'b0};
        end else if (!reg_shift) begin
            case (so[6:5])
                SH_LSL: d.steps = {1'b0, n};
                SH_ROR: begin
                    if (n == 5'd0) begin
                        d.op    = OP_RRX;
                        d.steps = 6'd1;
                    end else begin
                        d.steps = {1'b0, n};
                    end
                end
                default: d.steps = (n == 5'd0) ? 6'd32 : {1'b0, n};
            endcase
        end else if (rs != 8'd0) begin
            if (so[6:5] == SH_ROR)
                d.steps = {1'b0, a_m1} + 6'd1;
            else
                d.steps = (rs > 8'(MAX_STEPS)) ? MAX_STEPS : rs[5:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// rtl/shift_step_unit.sv - combinational up-to-STEP single-bit shift steps with last bit out
module shift_step_unit
    import arm_shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic [31:0] i_val,
    input  op_t         i_op,
    input  logic [2:0]  i_k,
    input  logic        i_fill,
    input  logic        i_carry,
    output logic [31:0] o_val,
    output logic        o_carry
);

    logic [31:0] w_v;
    logic        w_c;

    always_comb begin
        w_v = i_val;
        w_c = i_carry;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(i_k)) begin
                case (i_op)
                    OP_LSL: begin w_c = w_v[31]; w_v = {w_v[30:0], 1'b0};    end
                    OP_LSR: begin w_c = w_v[0];  w_v = {1'b0, w_v[31:1]};    end
                    OP_ASR: begin w_c = w_v[0];  w_v = {w_v[31], w_v[31:1]}; end
                    OP_ROR: begin w_c = w_v[0];  w_v = {w_v[0], w_v[31:1]};  end
                    default: begin w_c = w_v[0]; w_v = {i_fill, w_v[31:1]};  end
                endcase
            end
        end
    end

    assign o_val   = w_v;
    assign o_carry = w_c;

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative ARM operand-2 shifter with valid/ready result handshake
module shift_sequencer
    import arm_shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        imm,
    input  logic        reg_shift,
    input  logic [11:0] shift_operand,
    input  logic [31:0] val_rm,
    input  logic [7:0]  val_rs,
    input  logic        carry_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] val_2,
    output logic        carry_out,
    output logic        busy
);

    state_t      r_state;
    op_t         r_op;
    logic [5:0]  r_rem;
    logic [31:0] r_val;
    logic        r_carry;
    logic        r_fill;
    logic [31:0] r_val_2;
    logic        r_carry_out;

    decode_t     w_dec;
    logic [31:0] w_operand;
    logic [2:0]  w_k;
    logic [31:0] w_next;
    logic        w_cout;

    assign w_dec     = decode_shift(imm, reg_shift, shift_operand, val_rs);
    assign w_operand = imm ? {24'b0, shift_operand[7:0]} : val_rm;
    assign w_k       = (r_rem > 6'(STEP)) ? 3'(STEP) : r_rem[2:0];

    shift_step_unit #(.STEP(STEP)) u_step (
        .i_val   (r_val),
        .i_op    (r_op),
        .i_k     (w_k),
        .i_fill  (r_fill),
        .i_carry (r_carry),
        .o_val   (w_next),
        .o_carry (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LSL;
            r_rem       <= 6'd0;
            r_val       <= 32'd0;
            r_carry     <= 1'b0;
            r_fill      <= 1'b0;
            r_val_2     <= 32'd0;
            r_carry_out <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LSL;
            r_rem       <= 6'd0;
            r_val       <= 32'd0;
            r_carry     <= 1'b0;
            r_fill      <= 1'b0;
            r_val_2     <= 32'd0;
            r_carry_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op    <= w_dec.op;
                        r_val   <= w_operand;
                        r_carry <= carry_in;
                        r_fill  <= carry_in;
                        // Zero-step requests skip SHIFT and present the operand unchanged.
                        if (w_dec.steps == 6'd0) begin
                            r_val_2     <= w_operand;
                            r_carry_out <= carry_in;
                            r_state     <= S_DONE;
                        end else begin
                            r_rem   <= (w_dec.steps > MAX_STEPS) ? MAX_STEPS : w_dec.steps;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_val   <= w_next;
                    r_carry <= w_cout;
                    r_rem   <= r_rem - {3'b0, w_k};
                    if (r_rem == {3'b0, w_k}) begin
                        r_val_2     <= w_next;
                        r_carry_out <= w_cout;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_SHIFT) || ((r_state == S_DONE) && !out_ready);
    assign val_2     = r_val_2;
    assign carry_out = r_carry_out;

endmodule
